regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Sequences access to the 32x32 register file in the RV32I pipeline.
- Tracks which architectural registers have a write outstanding (scoreboard) and stalls issue on RAW/WAW hazards.
- Shares the register file's single write port between the ALU writeback and the variable-latency load writeback using a two-way round-robin arbiter.
- Drives the register file's RegWrite, rd and write-data inputs from a registered commit stage.

Parameters:
- XLEN, 32, data width.
- MAX_LOADS, 4, maximum outstanding loads; must be >= 1.
- CNT_W, 3, width of the load counter; must satisfy 2^CNT_W > MAX_LOADS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1  in  5  source register 1.
- issue_rs2  in  5  source register 2.
- issue_rd  in  5  destination register.
- issue_uses_rs1  in  1  rs1 is read.
- issue_uses_rs2  in  1  rs2 is read.
- issue_writes_rd  in  1  instruction writes rd.
- issue_is_load  in  1  instruction is a load.
- issue_ready  out  1  issue accepted this cycle when high together with issue_valid.
- alu_wb_valid  in  1  ALU result available.
- alu_wb_rd  in  5  ALU destination register.
- alu_wb_data  in  XLEN  ALU result.
- alu_wb_ready  out  1  ALU writeback granted.
- ld_wb_valid  in  1  load data returned.
- ld_wb_rd  in  5  load destination register.
- ld_wb_data  in  XLEN  load data.
- ld_wb_ready  out  1  load writeback granted.
- rf_reg_write  out  1  register file RegWrite.
- rf_rd  out  5  register file write address.
- rf_rd_write_data  out  XLEN  register file write data.
- pending  out  32  scoreboard bit vector; bit 0 is always 0.
- loads_outstanding  out  CNT_W  count of issued loads not yet written back.

Behaviour:
- Reset (asynchronous, active-high): pending=0, loads_outstanding=0, rf_reg_write=0, rf_rd=0, rf_rd_write_data=0, rr_last=ALU.
- Commit mask: cmask = one-hot(rf_rd) when rf_reg_write=1, else 0. eff_pending = pending & ~cmask. The register file forwards its write data combinationally, so a register committing this cycle is readable this cycle.
- Hazard: a hazard exists if any of the following holds against eff_pending:
  - issue_uses_rs1 and rs1!=0 and rs1 is pending;
  - issue_uses_rs2 and rs2!=0 and rs2 is pending;
  - issue_writes_rd and rd!=0 and rd is pending (WAW).
- issue_ready = !hazard && !(issue_is_load && loads_outstanding==MAX_LOADS). It is combinational and does not depend on issue_valid.
- Issue handshake (issue_valid && issue_ready): if issue_writes_rd and rd!=0, set pending[rd] at the next edge. If issue_is_load, increment the load counter.
- Arbitration (combinational grant):
  - One requester valid: that requester is granted.
  - Both valid: grant the requester not in rr_last; rr_last updates to the granted source on every grant.
  - At most one of alu_wb_ready / ld_wb_ready is high in a cycle.
- Commit stage:
  - On grant, at the next edge: rf_reg_write = (granted rd != 0), rf_rd = granted rd, rf_rd_write_data = granted data. Latency from grant to register file write is 1 cycle.
  - With no grant, rf_reg_write = 0 at the next edge; rf_rd and rf_rd_write_data hold their values.
- Pending clear: pending[rf_rd] clears at the edge ending the cycle in which rf_reg_write=1.
- Simultaneous clear and set of the same register (a new issue with rd==rf_rd during the commit cycle): the set wins and pending stays 1.
- Load counter:
  - Decrements on a load grant (ld_wb_valid && ld_wb_ready).
  - Simultaneous load issue and load grant: the count is unchanged.
  - The counter never wraps. A load grant at count 0 is a protocol error, flagged by an assertion; the counter saturates at 0.
- Writeback with rd=0: the requester is granted and consumed, but rf_reg_write stays 0.
- Reset mid-operation: all scoreboard and counter state is lost. Upstream flushes in-flight ops in the same reset.

Decomposition:
- Shared package rv_pkg:
  - XLEN and REG_COUNT=32;
  - typedef reg_idx_t (5 bits);
  - enum wb_src_t {WB_ALU, WB_LOAD} for rr_last and the grant encoding.
- One natural sub-module, rr_arb2: a two-requester round-robin arbiter holding rr_last, with inputs req[1:0] and output gnt[1:0]. The remaining logic (scoreboard, load counter, commit register) stays in the top level.

Test Plan:
- Reset, then issue ADD rd=5 -> pending[5]=1. Issue rs1=5 -> issue_ready=0. ALU wb rd=5, data 0xDEADBEEF -> next cycle rf_reg_write=1, rf_rd=5, rf_rd_write_data=0xDEADBEEF. In that same cycle, an issue with rs1=5 gets issue_ready=1; pending[5]=0 after the edge.
- alu_wb_valid and ld_wb_valid held high for 4 cycles, rd=3 and rd=4 -> grants LOAD, ALU, LOAD, ALU; rf_rd sequence 3,4,3,4 (ALU rd=4, load rd=3).
- Issue 4 loads to rd=1..4 -> loads_outstanding=4. A fifth load to rd=6 sees issue_ready=0; a non-load in the same state is accepted. One load wb -> count 3 and the fifth load is accepted.
- In the commit cycle of rd=7, issue an instruction with issue_writes_rd=1, rd=7 -> issue_ready=1 and pending[7]=1 after the edge.
- ALU wb with rd=0 -> alu_wb_ready=1, rf_reg_write stays 0, pending unchanged. Issue rs1=0 is never stalled.
- Assert rst asynchronously between clock edges with pending=0x0000_00F0 and count=2 -> all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I register-file types: data width, register index type and writeback source encoding.
package rv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Writeback source; also the bit position of that source in arbiter req/gnt vectors.
    typedef enum logic {
        WB_ALU  = 1'b0,
        WB_LOAD = 1'b1
    } wb_src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 = ALU, bit 1 = load writeback.
module rr_arb2
    import rv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_t rr_last_q;
    wb_src_t rr_last_d;

    // Grant the sole requester, or on contention the one not granted last.
    always_comb begin
        gnt       = 2'b00;
        rr_last_d = rr_last_q;
        if (req == 2'b11) begin
            if (rr_last_q == WB_ALU) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end else begin
            gnt = req;
        end
        if (gnt[1]) begin
            rr_last_d = WB_LOAD;
        end else if (gnt[0]) begin
            rr_last_d = WB_ALU;
        end
    end

    // Remember the most recently granted source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= WB_ALU;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write scheduler: hazard scoreboard, load tracking and a shared write-port commit stage.
module regfile_wb_scheduler #(
    parameter int unsigned XLEN      = rv_pkg::XLEN,
    parameter int unsigned MAX_LOADS = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  issue_valid,
    input  rv_pkg::reg_idx_t      issue_rs1,
    input  rv_pkg::reg_idx_t      issue_rs2,
    input  rv_pkg::reg_idx_t      issue_rd,
    input  logic                  issue_uses_rs1,
    input  logic                  issue_uses_rs2,
    input  logic                  issue_writes_rd,
    input  logic                  issue_is_load,
    output logic                  issue_ready,

    input  logic                  alu_wb_valid,
    input  rv_pkg::reg_idx_t      alu_wb_rd,
    input  logic [XLEN-1:0]       alu_wb_data,
    output logic                  alu_wb_ready,

    input  logic                  ld_wb_valid,
    input  rv_pkg::reg_idx_t      ld_wb_rd,
    input  logic [XLEN-1:0]       ld_wb_data,
    output logic                  ld_wb_ready,

    output logic                  rf_reg_write,
    output rv_pkg::reg_idx_t      rf_rd,
    output logic [XLEN-1:0]       rf_rd_write_data,

    output logic [31:0]           pending,
    output logic [CNT_W-1:0]      loads_outstanding
);

    import rv_pkg::*;

    logic [REG_COUNT-1:0] pending_q, pending_d;
    logic [REG_COUNT-1:0] cmask, eff_pending, set_mask;
    logic [CNT_W-1:0]     loads_q, loads_d;
    logic                 rf_we_q, rf_we_d;
    reg_idx_t             rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]      rf_data_q, rf_data_d;

    logic                 hazard;
    logic                 loads_full;
    logic                 issue_fire;
    logic                 ld_issue;
    logic                 ld_grant;
    logic [1:0]           req;
    logic [1:0]           gnt;

    // Write port arbitration between ALU (bit 0) and load (bit 1) writeback.
    assign req = {ld_wb_valid, alu_wb_valid};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign alu_wb_ready = gnt[0];
    assign ld_wb_ready  = gnt[1];
    assign ld_grant     = gnt[1];

    // Register being written this cycle is forwarded by the regfile, so it no longer blocks issue.
    always_comb begin
        cmask = '0;
        if (rf_we_q) begin
            cmask = REG_COUNT'(1) << rf_rd_q;
        end
        eff_pending = pending_q & ~cmask;
    end

    // RAW/WAW hazard detection and load-capacity check.
    always_comb begin
        hazard = 1'b0;
        if (issue_uses_rs1 && (issue_rs1 != '0) && eff_pending[issue_rs1]) begin
            hazard = 1'b1;
        end
        if (issue_uses_rs2 && (issue_rs2 != '0) && eff_pending[issue_rs2]) begin
            hazard = 1'b1;
        end
        if (issue_writes_rd && (issue_rd != '0) && eff_pending[issue_rd]) begin
            hazard = 1'b1;
        end
        loads_full  = (loads_q == CNT_W'(MAX_LOADS));
        issue_ready = !hazard && !(issue_is_load && loads_full);
        issue_fire  = issue_valid && issue_ready;
        ld_issue    = issue_fire && issue_is_load;
    end

    // Scoreboard next state: commit clears, a new issue sets (set wins on the same register).
    always_comb begin
        set_mask = '0;
        if (issue_fire && issue_writes_rd && (issue_rd != '0)) begin
            set_mask = REG_COUNT'(1) << issue_rd;
        end
        pending_d    = eff_pending | set_mask;
        pending_d[0] = 1'b0;
    end

    // Outstanding-load counter; saturates at zero on an unexpected load return.
    always_comb begin
        loads_d = loads_q;
        unique case ({ld_issue, ld_grant})
            2'b10: loads_d = loads_q + CNT_W'(1);
            2'b01: loads_d = (loads_q == '0) ? '0 : loads_q - CNT_W'(1);
            default: loads_d = loads_q;
        endcase
    end

    // Commit stage next state: capture the granted writeback, hold address/data when idle.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (gnt[1]) begin
            rf_we_d   = (ld_wb_rd != '0);
            rf_rd_d   = ld_wb_rd;
            rf_data_d = ld_wb_data;
        end else if (gnt[0]) begin
            rf_we_d   = (alu_wb_rd != '0);
            rf_rd_d   = alu_wb_rd;
            rf_data_d = alu_wb_data;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            loads_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            pending_q <= pending_d;
            loads_q   <= loads_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    // A load return with no load outstanding is an upstream protocol violation.
    assert property (@(posedge clk) disable iff (rst) !(ld_grant && (loads_q == '0)));

    assign rf_reg_write      = rf_we_q;
    assign rf_rd             = rf_rd_q;
    assign rf_rd_write_data  = rf_data_q;
    assign pending           = pending_q;
    assign loads_outstanding = loads_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a commit scoreboard.
module tb_regfile_wb_scheduler;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } commit_t;

    commit_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_uses_rs1, issue_uses_rs2, issue_writes_rd, issue_is_load;
    logic        issue_ready;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        ld_wb_valid;
    logic [4:0]  ld_wb_rd;
    logic [31:0] ld_wb_data;
    logic        ld_wb_ready;
    logic        rf_reg_write;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_write_data;
    logic [31:0] pending;
    logic [2:0]  loads_outstanding;

    regfile_wb_scheduler #(.XLEN(32), .MAX_LOADS(4), .CNT_W(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .issue_valid       (issue_valid),
        .issue_rs1         (issue_rs1),
        .issue_rs2         (issue_rs2),
        .issue_rd          (issue_rd),
        .issue_uses_rs1    (issue_uses_rs1),
        .issue_uses_rs2    (issue_uses_rs2),
        .issue_writes_rd   (issue_writes_rd),
        .issue_is_load     (issue_is_load),
        .issue_ready       (issue_ready),
        .alu_wb_valid      (alu_wb_valid),
        .alu_wb_rd         (alu_wb_rd),
        .alu_wb_data       (alu_wb_data),
        .alu_wb_ready      (alu_wb_ready),
        .ld_wb_valid       (ld_wb_valid),
        .ld_wb_rd          (ld_wb_rd),
        .ld_wb_data        (ld_wb_data),
        .ld_wb_ready       (ld_wb_ready),
        .rf_reg_write      (rf_reg_write),
        .rf_rd             (rf_rd),
        .rf_rd_write_data  (rf_rd_write_data),
        .pending           (pending),
        .loads_outstanding (loads_outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_commit(input string tag);
        commit_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed commit with empty scoreboard, expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".we"},   32'(rf_reg_write), 32'(e.we));
            chk({tag, ".rd"},   32'(rf_rd),        32'(e.rd));
            chk({tag, ".data"}, rf_rd_write_data,  e.data);
        end
    endtask

    task automatic set_issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic u1, input logic u2, input logic wr, input logic ld);
        issue_valid     = 1'b1;
        issue_rs1       = rs1;
        issue_rs2       = rs2;
        issue_rd        = rd;
        issue_uses_rs1  = u1;
        issue_uses_rs2  = u2;
        issue_writes_rd = wr;
        issue_is_load   = ld;
    endtask

    task automatic clr_issue();
        issue_valid     = 1'b0;
        issue_rs1       = '0;
        issue_rs2       = '0;
        issue_rd        = '0;
        issue_uses_rs1  = 1'b0;
        issue_uses_rs2  = 1'b0;
        issue_writes_rd = 1'b0;
        issue_is_load   = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic wr, input logic ld,
                         input logic exp_ready, input string tag);
        set_issue(rs1, rs2, rd, u1, u2, wr, ld);
        #1;
        chk({tag, ".ready"}, 32'(issue_ready), 32'(exp_ready));
        step();
        clr_issue();
    endtask

    task automatic alu_wb(input logic [4:0] rd, input logic [31:0] data, input string tag);
        alu_wb_valid = 1'b1;
        alu_wb_rd    = rd;
        alu_wb_data  = data;
        #1;
        chk({tag, ".alu_rdy"}, 32'(alu_wb_ready), 32'd1);
        chk({tag, ".ld_rdy"},  32'(ld_wb_ready),  32'd0);
        exp_q.push_back(commit_t'{we: (rd != 5'd0), rd: rd, data: data});
        step();
        alu_wb_valid = 1'b0;
        check_commit(tag);
    endtask

    task automatic ld_wb(input logic [4:0] rd, input logic [31:0] data, input string tag);
        ld_wb_valid = 1'b1;
        ld_wb_rd    = rd;
        ld_wb_data  = data;
        #1;
        chk({tag, ".ld_rdy"},  32'(ld_wb_ready),  32'd1);
        chk({tag, ".alu_rdy"}, 32'(alu_wb_ready), 32'd0);
        exp_q.push_back(commit_t'{we: (rd != 5'd0), rd: rd, data: data});
        step();
        ld_wb_valid = 1'b0;
        check_commit(tag);
    endtask

    initial begin
        logic exp_ld;
        rst = 1'b1;
        clr_issue();
        alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
        ld_wb_valid  = 1'b0; ld_wb_rd  = '0; ld_wb_data  = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst.pending", pending, 32'h0);
        chk("rst.loads",   32'(loads_outstanding), 32'd0);
        chk("rst.we",      32'(rf_reg_write), 32'd0);
        chk("rst.rd",      32'(rf_rd), 32'd0);
        chk("rst.data",    rf_rd_write_data, 32'h0);
        chk("rst.ready",   32'(issue_ready), 32'd1);

        // RAW stall and release in the commit cycle
        issue(0, 0, 5, 0, 0, 1, 0, 1, "A.add_rd5");
        chk("A.pending5", pending, 32'h0000_0020);
        set_issue(5, 0, 0, 1, 0, 0, 0);
        #1;
        chk("A.raw_stall", 32'(issue_ready), 32'd0);
        clr_issue();
        alu_wb(5, 32'hDEAD_BEEF, "A.wb5");
        set_issue(5, 0, 0, 1, 0, 0, 0);
        #1;
        chk("A.fwd_ready", 32'(issue_ready), 32'd1);
        chk("A.pend_held", pending, 32'h0000_0020);
        step();
        clr_issue();
        chk("A.pend_clear", pending, 32'h0);

        // Round-robin alternation under contention
        issue(0, 0, 3, 0, 0, 1, 1, 1, "B.ld3");
        issue(0, 0, 0, 0, 0, 0, 1, 1, "B.ld_nord");
        chk("B.loads2", 32'(loads_outstanding), 32'd2);
        chk("B.pend3",  pending, 32'h0000_0008);
        for (int k = 0; k < 4; k++) begin
            alu_wb_valid = 1'b1; alu_wb_rd = 5'd4; alu_wb_data = 32'h2000_0000 + 32'(k);
            ld_wb_valid  = 1'b1; ld_wb_rd  = 5'd3; ld_wb_data  = 32'h1000_0000 + 32'(k);
            exp_ld = ((k % 2) == 0);
            #1;
            chk("B.ld_rdy",  32'(ld_wb_ready),  32'(exp_ld));
            chk("B.alu_rdy", 32'(alu_wb_ready), 32'(!exp_ld));
            if (exp_ld) exp_q.push_back(commit_t'{we: 1'b1, rd: 5'd3, data: 32'h1000_0000 + 32'(k)});
            else        exp_q.push_back(commit_t'{we: 1'b1, rd: 5'd4, data: 32'h2000_0000 + 32'(k)});
            step();
            check_commit("B.commit");
        end
        alu_wb_valid = 1'b0;
        ld_wb_valid  = 1'b0;
        chk("B.loads0", 32'(loads_outstanding), 32'd0);
        chk("B.pend0",  pending, 32'h0);
        step();
        chk("B.we_drop", 32'(rf_reg_write), 32'd0);

        // Load capacity limit
        for (int i = 1; i <= 4; i++) issue(0, 0, 5'(i), 0, 0, 1, 1, 1, "C.ld");
        chk("C.loads4", 32'(loads_outstanding), 32'd4);
        chk("C.pend",   pending, 32'h0000_001E);
        set_issue(0, 0, 6, 0, 0, 1, 1);
        #1;
        chk("C.ld5_blocked", 32'(issue_ready), 32'd0);
        set_issue(0, 0, 8, 0, 0, 1, 0);
        #1;
        chk("C.alu_ok", 32'(issue_ready), 32'd1);
        step();
        clr_issue();
        chk("C.pend8", pending, 32'h0000_011E);
        ld_wb(1, 32'h1111_1111, "C.wb1");
        chk("C.loads3", 32'(loads_outstanding), 32'd3);
        issue(0, 0, 6, 0, 0, 1, 1, 1, "C.ld5_ok");
        chk("C.loads4b", 32'(loads_outstanding), 32'd4);
        chk("C.pend6",   pending, 32'h0000_015C);
        ld_wb(2, 32'h2222_2222, "C.wb2");
        chk("C.loads3b", 32'(loads_outstanding), 32'd3);
        set_issue(0, 0, 9, 0, 0, 1, 1);
        #1;
        chk("C.ld9_ready", 32'(issue_ready), 32'd1);
        ld_wb(3, 32'h3333_3333, "C.wb3_sim");
        clr_issue();
        chk("C.loads_same", 32'(loads_outstanding), 32'd3);
        chk("C.pend9", pending, 32'h0000_0358);
        ld_wb(4, 32'h4444_4444, "C.wb4");
        ld_wb(6, 32'h6666_6666, "C.wb6");
        ld_wb(9, 32'h9999_9999, "C.wb9");
        alu_wb(8, 32'h8888_8888, "C.wb8");
        chk("C.loads0", 32'(loads_outstanding), 32'd0);
        step();
        chk("C.pend0", pending, 32'h0);

        // Set wins over clear on the same register
        issue(0, 0, 7, 0, 0, 1, 0, 1, "D.rd7");
        alu_wb(7, 32'h7777_7777, "D.wb7");
        set_issue(0, 0, 7, 0, 0, 1, 0);
        #1;
        chk("D.waw_ready", 32'(issue_ready), 32'd1);
        step();
        clr_issue();
        chk("D.pend7", pending, 32'h0000_0080);

        // Writeback to x0 and x0 sources
        alu_wb(0, 32'h0BAD_F00D, "E.wb0");
        chk("E.pend_kept", pending, 32'h0000_0080);
        step();
        chk("E.pend_kept2", pending, 32'h0000_0080);
        issue(0, 0, 0, 1, 1, 0, 0, 1, "E.rs0");
        alu_wb(7, 32'h7777_0007, "E.wb7");
        step();
        chk("E.pend0", pending, 32'h0);

        // Asynchronous reset mid-operation
        issue(0, 0, 4, 0, 0, 1, 1, 1, "F.ld4");
        issue(0, 0, 5, 0, 0, 1, 1, 1, "F.ld5");
        issue(0, 0, 6, 0, 0, 1, 0, 1, "F.op6");
        issue(0, 0, 7, 0, 0, 1, 0, 1, "F.op7");
        chk("F.pend", pending, 32'h0000_00F0);
        chk("F.loads2", 32'(loads_outstanding), 32'd2);
        alu_wb(9, 32'hCAFE_F00D, "F.wb9");
        #2;
        rst = 1'b1;
        #1;
        chk("F.rst_pending", pending, 32'h0);
        chk("F.rst_loads",   32'(loads_outstanding), 32'd0);
        chk("F.rst_we",      32'(rf_reg_write), 32'd0);
        chk("F.rst_rd",      32'(rf_rd), 32'd0);
        chk("F.rst_data",    rf_rd_write_data, 32'h0);
        #3;
        rst = 1'b0;
        chk("end.sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
